shot_resolver: RTL and testbench

SHOT_RESOLVER -- requirements
Module: shot_resolver

---
 rtl/shot_resolver_if.sv | 31 +++
 rtl/shot_resolver.sv | 151 +++++++++++++++
 tb/tb_shot_resolver.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shot_resolver_if.sv
// Controller <-> shot_resolver signal bundle.
// The master side (game controller) loads the board, issues shots and
// consumes responses; the slave side (shot_resolver) reports readiness,
// response codes and the remaining ship-cell count.
interface shot_resolver_if;
    logic       place_valid;
    logic [2:0] place_row;
    logic [2:0] place_col;
    logic       start;
    logic       shot_valid;
    logic [2:0] shot_row;
    logic [2:0] shot_col;
    logic       shot_ready;
    logic       resp_valid;
    logic [1:0] resp_code;
    logic       resp_ready;
    logic [4:0] cells_left;
    logic       all_sunk;

    modport master (
        output place_valid, place_row, place_col, start,
        output shot_valid, shot_row, shot_col, resp_ready,
        input  shot_ready, resp_valid, resp_code, cells_left, all_sunk
    );

    modport slave (
        input  place_valid, place_row, place_col, start,
        input  shot_valid, shot_row, shot_col, resp_ready,
        output shot_ready, resp_valid, resp_code, cells_left, all_sunk
    );
endinterface

// File: rtl/shot_resolver.sv
// Battleship-style shot resolver for one N x N board.
// LOAD collects ship cells, ARMED waits for a shot, CHECK resolves it in a
// single cycle, RESP holds the response until the controller takes it, and
// DONE parks the block once every ship cell has been hit.
// Response codes: 00 miss, 01 hit, 10 repeat, 11 invalid coordinate.
module shot_resolver #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst,
    shot_resolver_if.slave ctrl
);

    localparam int         CELLS     = N * N;
    localparam int         IDX_W     = $clog2(CELLS);
    localparam logic [2:0] EDGE      = 3'(N);
    localparam logic [4:0] CELLS_MAX = 5'(CELLS);

    localparam logic [1:0] CODE_MISS    = 2'b00;
    localparam logic [1:0] CODE_HIT     = 2'b01;
    localparam logic [1:0] CODE_REPEAT  = 2'b10;
    localparam logic [1:0] CODE_INVALID = 2'b11;

    typedef enum logic [2:0] {
        LOAD,
        ARMED,
        CHECK,
        RESP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CELLS-1:0] ship_q, ship_d;
    logic [CELLS-1:0] shot_q, shot_d;
    logic [4:0]       cells_q, cells_d;
    logic [2:0]       row_q, row_d;
    logic [2:0]       col_q, col_d;
    logic [1:0]       code_q, code_d;

    logic             place_in_range;
    logic             shot_in_range;
    logic [IDX_W-1:0] place_idx;
    logic [IDX_W-1:0] shot_idx;

    // Row-major flat index of a cell; only meaningful for in-range coordinates.
    function automatic logic [IDX_W-1:0] cell_index(input logic [2:0] r, input logic [2:0] c);
        logic [4:0] flat;
        flat = 5'({2'b00, r} * 5'(N)) + {2'b00, c};
        return flat[IDX_W-1:0];
    endfunction

    assign place_in_range = (ctrl.place_row < EDGE) && (ctrl.place_col < EDGE);
    assign shot_in_range  = (row_q < EDGE) && (col_q < EDGE);
    assign place_idx      = cell_index(ctrl.place_row, ctrl.place_col);
    assign shot_idx       = cell_index(row_q, col_q);

    // Moore outputs decoded from the state and the registered response/count.
    assign ctrl.shot_ready = (state_q == ARMED);
    assign ctrl.resp_valid = (state_q == RESP);
    assign ctrl.resp_code  = code_q;
    assign ctrl.cells_left = cells_q;
    assign ctrl.all_sunk   = (state_q == DONE);

    // Next-state and board/counter updates for every state.
    always_comb begin
        state_d = state_q;
        ship_d  = ship_q;
        shot_d  = shot_q;
        cells_d = cells_q;
        row_d   = row_q;
        col_d   = col_q;
        code_d  = code_q;

        case (state_q)
            LOAD: begin
                // start takes precedence; a placement in the same cycle is dropped
                if (ctrl.start) begin
                    if (cells_q != 5'd0) begin
                        state_d = ARMED;
                    end
                end else if (ctrl.place_valid && place_in_range &&
                             !ship_q[place_idx] && (cells_q < CELLS_MAX)) begin
                    ship_d[place_idx] = 1'b1;
                    cells_d           = cells_q + 5'd1;
                end
            end

            ARMED: begin
                if (ctrl.shot_valid) begin
                    row_d   = ctrl.shot_row;
                    col_d   = ctrl.shot_col;
                    state_d = CHECK;
                end
            end

            CHECK: begin
                if (!shot_in_range) begin
                    code_d = CODE_INVALID;
                end else if (shot_q[shot_idx]) begin
                    code_d = CODE_REPEAT;
                end else if (ship_q[shot_idx]) begin
                    code_d           = CODE_HIT;
                    shot_d[shot_idx] = 1'b1;
                    if (cells_q != 5'd0) begin
                        cells_d = cells_q - 5'd1;
                    end
                end else begin
                    code_d           = CODE_MISS;
                    shot_d[shot_idx] = 1'b1;
                end
                state_d = RESP;
            end

            RESP: begin
                if (ctrl.resp_ready) begin
                    state_d = (cells_q == 5'd0) ? DONE : ARMED;
                end
            end

            DONE: begin
                state_d = DONE;
            end

            default: begin
                state_d = LOAD;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= LOAD;
            ship_q  <= '0;
            shot_q  <= '0;
            cells_q <= 5'd0;
            row_q   <= 3'd0;
            col_q   <= 3'd0;
            code_q  <= CODE_MISS;
        end else begin
            state_q <= state_d;
            ship_q  <= ship_d;
            shot_q  <= shot_d;
            cells_q <= cells_d;
            row_q   <= row_d;
            col_q   <= col_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_shot_resolver.sv
// Self-checking bench for shot_resolver: directed scenarios followed by
// randomized games, all compared against a board-level reference model.
module tb_shot_resolver;

    localparam int N = 5;

    logic clk;
    logic rst;

    shot_resolver_if sif ();

    shot_resolver #(.N(N)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (sif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain board arrays plus game phase flags.
    bit ship_m [8][8];
    bit shot_m [8][8];
    int cells_m;
    bit armed_m;
    bit done_m;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sif.place_valid = 1'b0;
        sif.place_row   = 3'd0;
        sif.place_col   = 3'd0;
        sif.start       = 1'b0;
        sif.shot_valid  = 1'b0;
        sif.shot_row    = 3'd0;
        sif.shot_col    = 3'd0;
        sif.resp_ready  = 1'b0;
    endtask

    task automatic model_clear();
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                ship_m[r][c] = 1'b0;
                shot_m[r][c] = 1'b0;
            end
        end
        cells_m = 0;
        armed_m = 1'b0;
        done_m  = 1'b0;
    endtask

    // Applies rst=0 for one edge with whatever other inputs the caller set.
    task automatic do_reset();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        idle_inputs();
        model_clear();
        check_value("rst_cells_left", sif.cells_left, 0);
        check_value("rst_shot_ready", sif.shot_ready, 0);
        check_value("rst_resp_valid", sif.resp_valid, 0);
        check_value("rst_resp_code", sif.resp_code, 0);
        check_value("rst_all_sunk", sif.all_sunk, 0);
    endtask

    task automatic place(input int r, input int c);
        sif.place_valid = 1'b1;
        sif.place_row   = 3'(r);
        sif.place_col   = 3'(c);
        cycle();
        sif.place_valid = 1'b0;
        if (!armed_m && !done_m && r < N && c < N && !ship_m[r][c]) begin
            ship_m[r][c] = 1'b1;
            cells_m++;
        end
        check_value("place_cells_left", sif.cells_left, cells_m);
    endtask

    task automatic start_game(input bit with_place, input int r, input int c);
        sif.start       = 1'b1;
        sif.place_valid = with_place;
        sif.place_row   = 3'(r);
        sif.place_col   = 3'(c);
        cycle();
        sif.start       = 1'b0;
        sif.place_valid = 1'b0;
        if (cells_m > 0) armed_m = 1'b1;
        check_value("start_shot_ready", sif.shot_ready, armed_m);
        check_value("start_cells_left", sif.cells_left, cells_m);
    endtask

    task automatic fire(input int r, input int c, input int hold, input bit ack);
        int exp_code;
        check_value("pre_shot_ready", sif.shot_ready, 1);
        sif.shot_valid = 1'b1;
        sif.shot_row   = 3'(r);
        sif.shot_col   = 3'(c);
        cycle();
        sif.shot_valid = 1'b0;
        check_value("check_resp_valid", sif.resp_valid, 0);
        check_value("check_shot_ready", sif.shot_ready, 0);

        if (r >= N || c >= N) begin
            exp_code = 3;
        end else if (shot_m[r][c]) begin
            exp_code = 2;
        end else if (ship_m[r][c]) begin
            exp_code = 1;
            shot_m[r][c] = 1'b1;
            cells_m--;
        end else begin
            exp_code = 0;
            shot_m[r][c] = 1'b1;
        end

        cycle();
        check_value("resp_valid", sif.resp_valid, 1);
        check_value("resp_code", sif.resp_code, exp_code);
        check_value("resp_cells_left", sif.cells_left, cells_m);
        for (int h = 0; h < hold; h++) begin
            cycle();
            check_value("hold_resp_valid", sif.resp_valid, 1);
            check_value("hold_resp_code", sif.resp_code, exp_code);
            check_value("hold_shot_ready", sif.shot_ready, 0);
        end
        $display("shot (%0d,%0d) code=%0d expected=%0d cells_left=%0d", r, c,
                 sif.resp_code, exp_code, sif.cells_left);

        if (ack) begin
            sif.resp_ready = 1'b1;
            cycle();
            sif.resp_ready = 1'b0;
            if (cells_m == 0) begin
                done_m  = 1'b1;
                armed_m = 1'b0;
            end
            check_value("ack_resp_valid", sif.resp_valid, 0);
            check_value("ack_all_sunk", sif.all_sunk, done_m);
            check_value("ack_shot_ready", sif.shot_ready, !done_m);
        end
    endtask

    initial begin
        int q [$];
        int pick;
        int shots;

        idle_inputs();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        do_reset();

        // Empty board: start alone, then start with a simultaneous placement.
        start_game(1'b0, 0, 0);
        start_game(1'b1, 1, 1);

        // Duplicate and out-of-range placements are ignored.
        place(0, 0);
        place(0, 1);
        place(0, 1);
        place(5, 0);
        check_value("load_cells_two", sif.cells_left, 2);
        start_game(1'b0, 0, 0);

        // Directed shots: hit, repeat, miss, invalid with held response, final hit.
        fire(0, 0, 0, 1'b1);
        fire(0, 0, 0, 1'b1);
        fire(2, 3, 0, 1'b1);
        fire(7, 7, 4, 1'b1);
        check_value("invalid_no_change", sif.cells_left, 1);
        fire(0, 1, 1, 1'b1);
        check_value("done_all_sunk", sif.all_sunk, 1);

        // In DONE, shots and placements have no effect.
        sif.shot_valid  = 1'b1;
        sif.place_valid = 1'b1;
        sif.place_row   = 3'd3;
        sif.place_col   = 3'd3;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check_value("done_shot_ready", sif.shot_ready, 0);
            check_value("done_resp_valid", sif.resp_valid, 0);
            check_value("done_cells_left", sif.cells_left, 0);
            check_value("done_all_sunk_hold", sif.all_sunk, 1);
        end
        idle_inputs();

        // Randomized games against the reference model.
        for (int g = 0; g < 6; g++) begin
            do_reset();
            for (int p = 0; p < int'($urandom_range(1, 14)); p++) begin
                place(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
            end
            if (cells_m == 0) place(1, 2);
            start_game(g[0], int'($urandom_range(0, 4)), int'($urandom_range(0, 4)));
            shots = 0;
            while (!done_m && shots < 40) begin
                if ($urandom_range(0, 1) == 1) begin
                    q.delete();
                    for (int r = 0; r < N; r++) begin
                        for (int c = 0; c < N; c++) begin
                            if (ship_m[r][c] && !shot_m[r][c]) q.push_back(r * 8 + c);
                        end
                    end
                    pick = q[$urandom_range(0, q.size() - 1)];
                    fire(pick / 8, pick % 8, int'($urandom_range(0, 2)), 1'b1);
                end else begin
                    fire(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                         int'($urandom_range(0, 2)), 1'b1);
                end
                shots++;
            end
        end

        // Reset while a response is pending; reset outranks every other input.
        do_reset();
        place(2, 2);
        place(3, 4);
        start_game(1'b0, 0, 0);
        fire(3, 4, 1, 1'b0);
        sif.resp_ready = 1'b1;
        sif.shot_valid = 1'b1;
        sif.start      = 1'b1;
        do_reset();
        start_game(1'b0, 0, 0);
        check_value("post_rst_board_empty", sif.cells_left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
